// File: rtl/cargador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : cargador_pkg                                                 |
// | Purpose   : Shared types and constants for the boot-time program loader. |
// |             Holds the loader state encoding, stream framing sizes and    |
// |             the word-count width.                                        |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package cargador_pkg;

  // Bytes per instruction word and per word-count header.
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 2;

  // Header width follows from the header byte count (16 bits).
  localparam int unsigned COUNT_W = HDR_BYTES * 8;
  localparam int unsigned WORD_W  = WORD_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

endpackage : cargador_pkg
`default_nettype wire

// File: rtl/cargador_programa_ensamblador_palabra.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : ensamblador_palabra                                          |
// | Purpose   : 8->32 MSB-first shift register with a 2-bit byte counter.    |
// |             The first byte shifted in ends up in bits 31:24.             |
// | Ports     : CLK, RST_N   clock, async active-low reset                   |
// |             shift_en     shift byte_in into the word                     |
// |             clear        zero the word and the byte counter (priority)   |
// |             byte_in      incoming stream byte                            |
// |             word         assembled word (registered)                     |
// |             full         three bytes held: the next shift completes it   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module ensamblador_palabra
  import cargador_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[WORD_W-9:0], byte_in};
      // Wraps 3 -> 0 on the completing byte, ready for the next word.
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = word_q;
  // Asserted while the last byte of the word is pending, so the FSM can
  // move to WRITE on the same edge that accepts that byte.
  assign full = (cnt_q == 2'(WORD_BYTES - 1));

endmodule : ensamblador_palabra
`default_nettype wire

// File: rtl/cargador_programa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : cargador_programa                                            |
// | Purpose   : Boot-time program loader. Receives a 16-bit big-endian word  |
// |             count followed by 32-bit big-endian words over a byte        |
// |             valid/ready stream and writes them to consecutive word       |
// |             addresses of instruction memory, holding the CPU meanwhile.  |
// | Ports     : CLK, RST_N          clock, async active-low reset            |
// |             start               begin a load (IDLE/DONE/ERROR only)      |
// |             in_byte/in_valid    stream byte and its valid                |
// |             in_ready            byte accepted when in_valid && in_ready  |
// |             mem_we/addr/wdata   instruction-memory write port            |
// |             cpu_hold            stall the datapath                       |
// |             done / err          load complete / header rejected          |
// |             words_loaded        words written in current or last load    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module cargador_programa
  import cargador_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] words_loaded
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic [31:0]        addr_q, addr_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               asm_clear;
  logic               asm_full;
  logic [COUNT_W-1:0] hdr_count;
  logic [COUNT_W-1:0] words_next;

  // in_ready is a registered decode of the state, so the handshake never
  // depends combinationally on in_valid.
  assign accept     = in_valid && in_ready_q;
  assign hdr_count  = {count_q[COUNT_W-9:0], in_byte};
  assign words_next = words_q + 1'b1;

  ensamblador_palabra u_ensamblador (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .shift_en (accept && (state_q == ST_DATA)),
    .clear    (asm_clear),
    .byte_in  (in_byte),
    .word     (mem_wdata),
    .full     (asm_full)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      words_q <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_HDR_HI;
          count_d   = '0;
          words_d   = '0;
          addr_d    = BASE_ADDR;
          asm_clear = 1'b1;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          count_d = hdr_count;
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          count_d = hdr_count;
          if ((hdr_count == '0) || (hdr_count > COUNT_W'(MAX_WORDS))) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept && asm_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        words_d = words_next;
        addr_d  = addr_q + 32'(WORD_BYTES);
        state_d = (words_next == count_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet aligned
  // with the state they describe.
  always_comb begin
    in_ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                 (state_d == ST_DATA);
    mem_we_d   = (state_d == ST_WRITE);
    // ERROR keeps the hold: a partial or absent program must not run.
    cpu_hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule : cargador_programa
`default_nettype wire

// File: tb/tb_cargador_programa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_cargador_programa                                         |
// | Purpose   : Self-checking bench for cargador_programa. Loads are driven  |
// |             from byte streams; expected memory writes are derived from   |
// |             the stream and queued, and a monitor compares every mem_we   |
// |             pulse against the queue.                                     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_cargador_programa;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 CLK = ~CLK;

  cargador_programa #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge CLK);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Offer one byte (optionally after random idle gaps) and wait for the
  // handshake. Returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int waited);
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        @(negedge CLK);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      chk("handshake_timeout", 64'(waited), 64'd0);
      in_valid = 1'b0;
    end else begin
      @(negedge CLK);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Run one complete load of stream s and check the final status.
  task automatic run_load(input bq_t s, input bit gaps, input bit start_mid);
    logic [15:0] cnt;
    bit          bad_hdr;
    int          nw;
    int          waited;
    logic [63:0] ew[$];
    cnt     = {s[0], s[1]};
    bad_hdr = (cnt == 16'd0) || (int'(cnt) > MAXW);
    nw      = bad_hdr ? 0 : int'(cnt);
    for (int k = 0; k < nw; k++) begin
      ew.push_back({BASE + 32'(4 * k), s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
    end

    pulse_start();
    chk("start_words_loaded", 64'(words_loaded), 64'd0);
    chk("start_done", 64'(done), 64'd0);
    chk("start_err", 64'(err), 64'd0);
    chk("start_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("start_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < s.size(); i++) begin
      bit last_of_word;
      last_of_word = (i >= 2) && (((i - 2) % 4) == 3);
      if (last_of_word) exp_q.push_back(ew[(i - 2) / 4]);
      if (start_mid && i == 4) start = 1'b1;
      send_byte(s[i], gaps, waited);
      start = 1'b0;
      if (!gaps) begin
        chk("accept_latency", 64'(waited), (i >= 6 && ((i - 2) % 4) == 0) ? 64'd1 : 64'd0);
      end
      if (last_of_word) begin
        // Now in the write cycle: stream stalled, CPU still held.
        chk("write_in_ready", 64'(in_ready), 64'd0);
        chk("write_strobe", 64'(mem_we), 64'd1);
        chk("write_done", 64'(done), 64'd0);
        chk("write_cpu_hold", 64'(cpu_hold), 64'd1);
      end
    end
    in_valid = 1'b0;

    @(negedge CLK);
    chk("end_done", 64'(done), bad_hdr ? 64'd0 : 64'd1);
    chk("end_err", 64'(err), bad_hdr ? 64'd1 : 64'd0);
    chk("end_cpu_hold", 64'(cpu_hold), bad_hdr ? 64'd1 : 64'd0);
    chk("end_words_loaded", 64'(words_loaded), 64'(nw));
    chk("end_in_ready", 64'(in_ready), 64'd0);
    chk("end_mem_we", 64'(mem_we), 64'd0);
    chk("end_pending_writes", 64'(exp_q.size()), 64'd0);

    // Bytes offered while finished must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    repeat (2) @(negedge CLK);
    in_valid = 1'b0;
    chk("idle_err_held", 64'(err), bad_hdr ? 64'd1 : 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(BASE));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    bq_t s;
    int  waited;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_values("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Two-word load, continuous stream, then same stream with gaps.
    s = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    run_load(s, 1'b0, 1'b0);
    run_load(s, 1'b1, 1'b0);

    // Zero count, then recovery.
    s = '{8'h00, 8'h00};
    run_load(s, 1'b0, 1'b0);
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(s, 1'b0, 1'b0);

    // Oversize counts (low and high byte), then exactly MAX_WORDS.
    s = '{8'h00, 8'h05};
    run_load(s, 1'b0, 1'b0);
    s = '{8'h01, 8'h00};
    run_load(s, 1'b0, 1'b0);
    s = '{8'h00, 8'h04};
    for (int i = 0; i < 16; i++) s.push_back(8'($urandom));
    run_load(s, 1'b0, 1'b0);

    // Start pulsed during DATA is ignored.
    s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(s, 1'b0, 1'b1);

    // Reset after three data bytes.
    pulse_start();
    s = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3};
    foreach (s[i]) send_byte(s[i], 1'b0, waited);
    RST_N = 1'b0;
    #1;
    chk_reset_values("midreset");
    @(negedge CLK);
    in_valid = 1'b0;
    RST_N    = 1'b1;
    @(negedge CLK);
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
    run_load(s, 1'b0, 1'b0);

    // Randomized loads, including oversize headers.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] c;
      bit          gaps;
      c    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(5, 65535))
                                         : 16'($urandom_range(1, MAXW));
      gaps = 1'($urandom_range(0, 1));
      s    = '{c[15:8], c[7:0]};
      if (int'(c) <= MAXW) begin
        for (int i = 0; i < 4 * int'(c); i++) s.push_back(8'($urandom));
      end
      run_load(s, gaps, 1'b0);
    end

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cargador_programa
`default_nettype wire

// File: doc/cargador_programa.md
# cargador_programa

Boot-time program loader that writes the instruction memory read by the single-cycle datapath. It accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word-count header, then that many 32-bit big-endian instruction words. It writes each word into consecutive word-aligned instruction-memory addresses. It holds the processor (PC/register writes) stalled for the whole load, and releases it only after a complete, valid load.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be word-aligned.
- MAX_WORDS, 256, largest accepted word count; must be 1..65535.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE, ERROR.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts in_byte this cycle; a byte transfers when in_valid && in_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write: BASE_ADDR + 4*index.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keep the datapath stalled.
- done  out  1  load completed successfully.
- err  out  1  header rejected.
- words_loaded  out  16  count of words written in the current or last load.

## Operation
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start -> HDR_HI. This clears done, err, words_loaded and the byte counter, and sets cpu_hold=1.
- HDR_HI: accept byte -> count[15:8]; go to HDR_LO.
- HDR_LO: accept byte -> count[7:0].
  - If the full count is 0 or > MAX_WORDS -> ERROR, else -> DATA.
- DATA: accept bytes, shifting them in MSB-first (first byte -> bits 31:24). On the 4th accepted byte -> WRITE.
- WRITE: for one cycle,
  - mem_we=1, mem_addr=BASE_ADDR+4*words_loaded, mem_wdata=assembled word;
  - words_loaded increments at the end of the cycle;
  - if the new value == count -> DONE (cpu_hold=0, done=1), else -> DATA.
- ERROR: err=1, cpu_hold stays 1 (a partial or absent program must not run). Left only by start or reset.
- in_ready=1 only in HDR_HI, HDR_LO, DATA. It is 0 in IDLE, WRITE, DONE, ERROR, so bytes offered then are not consumed.
- start in HDR_HI/HDR_LO/DATA/WRITE is ignored.
- Address arithmetic is 32-bit modulo; wrap is not checked. BASE_ADDR + 4*MAX_WORDS is the integrator's responsibility.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_hold 0, done 0, err 0, words_loaded 0, count 0, byte counter 0.
- Reset mid-load returns to IDLE immediately with the values above. Words already written stay in memory; the loader does not scrub them.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- The 4th data byte is accepted on edge N. On edge N+1 the FSM enters WRITE, so mem_we/mem_addr/mem_wdata are valid in cycle N+1.
- Peak throughput is 4 bytes per 5 cycles; in_ready drops for the WRITE cycle.
- done and cpu_hold=0 take effect in the cycle after the last WRITE cycle.
- in_valid gaps stall the FSM in its current state with no state loss.
- start is sampled on an edge; the first byte can be accepted one cycle later.

## Structure
- Package cargador_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - constants WORD_BYTES=4 and HDR_BYTES=2;
  - localparam COUNT_W=16.
- Natural sub-module: ensamblador_palabra, an 8->32 MSB-first shift register with a 2-bit byte counter. It has inputs shift_en and clear and outputs word and full. The FSM uses full to decide DATA->WRITE.
- All remaining logic (FSM, counters, address generation) lives in cargador_programa.

## Test plan
- Load two words. Start, then bytes 00 02 8C 01 00 04 00 22 18 20 with in_valid held high.
  - Required: exactly two mem_we pulses, (0x0000_0000, 0x8C01_0004) then (0x0000_0004, 0x0022_1820).
  - Then done=1, cpu_hold=0, words_loaded=2.
- Zero count: header 00 00 -> ERROR.
  - Required: err=1, cpu_hold=1, no mem_we, in_ready=0.
  - A later start plus a valid header must recover to a normal load.
- Oversize count: MAX_WORDS=4, header 00 05 -> err=1, no writes.
- Backpressure and gaps: hold the byte following the 4th data byte valid throughout the WRITE cycle.
  - Required: that byte is not consumed during the WRITE cycle (in_ready=0) and is consumed in the next cycle.
  - Random in_valid gaps must produce the same memory image as the gap-free run.
- Reset mid-load: assert RST_N=0 after 3 data bytes.
  - Required: every output at its reset value on the same cycle.
  - A fresh one-word load (00 01 20 08 00 05) must write 0x2008_0005 at BASE_ADDR.
- Start handling:
  - start pulsed during DATA is ignored and the load completes normally.
  - start pulsed in DONE reloads, writing again from BASE_ADDR with words_loaded reset to 0.
